// File: rtl/load_store_unit.sv
// Load/store unit: turns decoded memory ops into a single word-wide memory access and returns
// extended load data or a fault. Optional macro LSU_LOAD_RESP_BYPASS_EN forwards load data from WAIT.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned REG_NUM_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_load,
  input  logic                     req_is_store,
  input  logic [2:0]               req_funct3,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [REG_NUM_WIDTH-1:0] req_rd,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [3:0]               mem_be,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_is_load,
  output logic [REG_NUM_WIDTH-1:0] resp_rd,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_fault
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic                     is_load_q;
  logic [2:0]               funct3_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [REG_NUM_WIDTH-1:0] rd_q;
  logic                     fault_q;
  logic [DATA_WIDTH-1:0]    data_q;

  logic                  accept;
  logic                  illegal;
  logic                  misaligned;
  logic                  fault_now;
  logic [3:0]            store_be;
  logic [DATA_WIDTH-1:0] store_wdata;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_data;

  // Ops with neither or both direction flags are silently dropped.
  assign accept = (state_q == StIdle) && req_valid && (req_is_load ^ req_is_store);

  always_comb begin
    if (req_is_load) begin
      illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end else begin
      illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    fault_now  = illegal || misaligned;
  end

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        store_be    = 4'b0001 << addr_q[1:0];
        store_wdata = {(DATA_WIDTH/8){wdata_q[7:0]}};
      end
      2'b01: begin
        store_be    = 4'b0011 << {addr_q[1], 1'b0};
        store_wdata = {(DATA_WIDTH/16){wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = fault_now ? StResp : StReq;
      StReq:  if (mem_req_ready) state_d = is_load_q ? StWait : StResp;
      StWait: begin
        if (mem_rsp_valid) begin
`ifdef LSU_LOAD_RESP_BYPASS_EN
          state_d = resp_ready ? StIdle : StResp;
`else
          state_d = StResp;
`endif
        end
      end
      StResp: if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_load_q <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      fault_q   <= 1'b0;
      data_q    <= '0;
    end else if (accept) begin
      is_load_q <= req_is_load;
      funct3_q  <= req_funct3;
      addr_q    <= req_addr;
      wdata_q   <= req_wdata;
      rd_q      <= req_rd;
      fault_q   <= fault_now;
      data_q    <= '0;
    end else if ((state_q == StWait) && mem_rsp_valid) begin
      data_q <= load_data;
    end
  end

  always_comb begin
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_be        = '0;
    mem_wdata     = '0;
    mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    resp_valid    = 1'b0;
    resp_is_load  = 1'b0;
    resp_rd       = '0;
    resp_data     = '0;
    resp_fault    = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StReq: begin
        mem_req_valid = 1'b1;
        mem_we        = ~is_load_q;
        if (!is_load_q) begin
          mem_be    = store_be;
          mem_wdata = store_wdata;
        end
      end
      StWait: begin
`ifdef LSU_LOAD_RESP_BYPASS_EN
        if (mem_rsp_valid) begin
          resp_valid   = 1'b1;
          resp_is_load = 1'b1;
          resp_rd      = rd_q;
          resp_data    = load_data;
        end
`endif
      end
      StResp: begin
        resp_valid   = 1'b1;
        resp_is_load = is_load_q;
        resp_rd      = rd_q;
        resp_data    = data_q;
        resp_fault   = fault_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle memory-access stage directly downstream of the instruction decoder.
- Consumes the decoded load/store fields (isLoad, isStore, funct3, rd) plus the computed effective address and store data.
- Drives a word-wide data-memory request/response port with byte enables.
- Returns sign- or zero-extended load data, or a misalignment/illegal flag, toward register writeback.

Parameters:
- DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes).
- ADDR_WIDTH, 32, byte-address width of req_addr.
- REG_NUM_WIDTH, 5, destination register number width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  decoded memory op valid.
- req_ready  out  1  unit can accept an op.
- req_is_load  in  1  op is a load.
- req_is_store  in  1  op is a store.
- req_funct3  in  3  MemFunct3: 000 SB/LB, 001 SH/LH, 010 W, 100 LBU, 101 LHU.
- req_addr  in  ADDR_WIDTH  effective byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- req_rd  in  REG_NUM_WIDTH  load destination register.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_WIDTH  word-aligned address (req_addr with [1:0] forced to 0).
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_rsp_valid  in  1  read data valid.
- mem_rdata  in  DATA_WIDTH  read word.
- resp_valid  out  1  completion valid.
- resp_ready  in  1  writeback accepts completion.
- resp_is_load  out  1  completion is a load (write rd).
- resp_rd  out  REG_NUM_WIDTH  latched rd.
- resp_data  out  DATA_WIDTH  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned or illegal funct3; no memory access was made.

Behaviour:
- Reset: state IDLE; req_ready=1; mem_req_valid=0, mem_we=0, mem_be=0; resp_valid=0, resp_fault=0, resp_is_load=0, resp_data=0, resp_rd=0.
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. Reset asserted mid-operation aborts the access and returns to IDLE next edge. A mem_rsp_valid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept when req_valid and (is_load xor is_store); latch all request fields.
  - req_valid with neither or both flags set: dropped, no response.
- Fault check at accept:
  - Illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - On fault, go IDLE->RESP with resp_fault=1 and resp_data=0.
  - Otherwise IDLE->REQ.
- REQ:
  - mem_req_valid=1, held stable until mem_req_ready.
  - On handshake: load -> WAIT; store -> RESP (posted write).
- WAIT:
  - Wait for mem_rsp_valid, which is never earlier than the cycle after the request handshake.
  - Register the extracted data, then -> RESP.
- RESP:
  - resp_valid=1, outputs stable until resp_ready; then -> IDLE.
  - A new request may be accepted in the cycle after the response handshake, never in the same cycle.
- Store byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Store wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extraction:
  - shifted = mem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- Zero-wait memory latency, accept edge to resp_valid:
  - load: 3 cycles;
  - store: 2 cycles;
  - fault: 1 cycle.

Optional Feature:
- Macro LSU_LOAD_RESP_BYPASS_EN.
- When defined, in WAIT with mem_rsp_valid=1:
  - resp_valid is asserted combinationally that cycle with the extracted data.
  - If resp_ready=1, go WAIT->IDLE, skipping RESP; load latency becomes 2.
  - If resp_ready=0, the data is registered and the FSM enters RESP as normal.
- When undefined: always registered through RESP, as above.

Test Plan:
- LB addr=0x0000_0003, mem_rdata=0x80AB_CD12, zero-wait, resp_ready=1 -> mem_addr=0x0000_0000, mem_be=0000, mem_we=0; resp_data=0xFFFF_FF80, resp_is_load=1, rd echoed; resp_valid 3 cycles after accept (2 with LSU_LOAD_RESP_BYPASS_EN).
- LHU addr=0x0000_0102, mem_rdata=0x8001_7FFF -> mem_addr=0x0000_0100; resp_data=0x0000_8001. LH at the same address -> resp_data=0xFFFF_8001.
- SB addr=0x0000_0011, wdata=0x1234_56A5, mem_req_ready low 3 cycles:
  - mem_req_valid held 4 cycles with mem_be=0010, mem_wdata=0xA5A5_A5A5, mem_we=1;
  - then resp_valid with resp_is_load=0, resp_data=0.
- Faults:
  - LW addr=0x0000_0006 -> resp_fault=1 one cycle after accept, mem_req_valid never asserts.
  - Store funct3=100 -> resp_fault=1, no memory access.
- resp_ready held low 5 cycles -> resp_valid and resp_data stable, req_ready=0 throughout; request accepted the cycle after the handshake.
- rst asserted in WAIT, then a late mem_rsp_valid -> after reset: IDLE, resp_valid stays 0, next LW at 0x0 completes normally.
